instr_sequencer: RTL and testbench

- Fetch/decode/execute controller for the EC1 16-entry, 8-bit combinational instruction ROM.
- Owns the program counter and drives the ROM address. Latches the returned instruction word and hands it to the datapath over a valid/ready handshake.
- Handles branches reported by the datapath, the HALT word, single-step, and restart. Sits between the instruction ROM and the EC1 execute datapath.

---
 rtl/ec1_pkg.sv | 20 ++
 rtl/ec1_pc_unit.sv | 52 +++++
 rtl/instr_sequencer.sv | 127 ++++++++++++
 tb/tb_instr_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ec1_pkg.sv
// Shared definitions for the EC1 instruction sequencer: FSM states,
// instruction word fields and reset constants.
package ec1_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_HALT
    } state_e;

    localparam logic [7:0] HALT_WORD = 8'hFF;
    localparam logic [3:0] RESET_PC  = 4'd0;

    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 5;
    localparam int OPR_W   = 5;

endpackage

// File: rtl/ec1_pc_unit.sv
// Program counter (branch load / increment with natural wrap) and the
// saturating count of retired instructions.
module ec1_pc_unit #(
    parameter int                ADDR_W   = 4,
    parameter int                CNT_W    = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              complete,
    input  logic              branch_en,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] pc,
    output logic [CNT_W-1:0]  retired
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  retired_q, retired_d;

    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        pc_d      = pc_q;
        retired_d = retired_q;
        if (clear) begin
            pc_d      = RESET_PC;
            retired_d = '0;
        end else if (complete) begin
            pc_d = branch_en ? branch_target : pc_q + ADDR_W'(1);
            if (retired_q != '1) begin
                retired_d = retired_q + CNT_W'(1);
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            retired_q <= '0;
        end else begin
            pc_q      <= pc_d;
            retired_q <= retired_d;
        end
    end

    assign pc      = pc_q;
    assign retired = retired_q;

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute controller for the EC1 instruction ROM: owns the FSM,
// the instruction register and the valid/ready hand-off to the datapath.
module instr_sequencer #(
    parameter int                ADDR_W    = 4,
    parameter int                DATA_W    = 8,
    parameter logic [ADDR_W-1:0] RESET_PC  = ec1_pkg::RESET_PC,
    parameter logic [DATA_W-1:0] HALT_WORD = ec1_pkg::HALT_WORD,
    parameter int                CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              step,
    input  logic              restart,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] ir,
    output logic [2:0]        opcode,
    output logic [4:0]        operand,
    output logic              exec_valid,
    input  logic              exec_ready,
    input  logic              branch_en,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);

    import ec1_pkg::*;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              single_q, single_d;
    logic              exec_valid_q, exec_valid_d;
    logic              busy_q, busy_d;
    logic              halted_q, halted_d;
    logic              complete;

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        single_d = single_q;
        complete = 1'b0;
        // restart outranks everything, including a coincident completion
        if (restart) begin
            state_d  = ST_IDLE;
            ir_d     = '0;
            single_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (run || step) begin
                        state_d  = ST_FETCH;
                        single_d = step && !run;
                    end
                end
                ST_FETCH: begin
                    ir_d    = rom_data;
                    state_d = ST_DECODE;
                end
                ST_DECODE: begin
                    state_d = (ir_q == HALT_WORD) ? ST_HALT : ST_EXECUTE;
                end
                ST_EXECUTE: begin
                    if (exec_ready) begin
                        complete = 1'b1;
                        state_d  = (run && !single_q) ? ST_FETCH : ST_IDLE;
                    end
                end
                ST_HALT: begin
                    state_d = ST_HALT;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // status outputs are registered from the next state
        exec_valid_d = (state_d == ST_EXECUTE);
        halted_d     = (state_d == ST_HALT);
        busy_d       = (state_d != ST_IDLE) && (state_d != ST_HALT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ir_q         <= '0;
            single_q     <= 1'b0;
            exec_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            ir_q         <= ir_d;
            single_q     <= single_d;
            exec_valid_q <= exec_valid_d;
            busy_q       <= busy_d;
            halted_q     <= halted_d;
        end
    end

    ec1_pc_unit #(
        .ADDR_W   (ADDR_W),
        .CNT_W    (CNT_W),
        .RESET_PC (RESET_PC)
    ) u_pc_unit (
        .clk           (clk),
        .rst           (rst),
        .clear         (restart),
        .complete      (complete),
        .branch_en     (branch_en),
        .branch_target (branch_target),
        .pc            (pc),
        .retired       (retired)
    );

    assign rom_addr   = pc;
    assign ir         = ir_q;
    assign opcode     = ir_q[OPC_MSB:OPC_LSB];
    assign operand    = ir_q[OPR_W-1:0];
    assign exec_valid = exec_valid_q;
    assign busy       = busy_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: table-driven program, scoreboard
// of expected completions, and hand-written multi-cycle corner cases.
module tb_instr_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       run = 1'b0;
    logic       step = 1'b0;
    logic       restart = 1'b0;
    logic       exec_ready = 1'b0;
    logic       branch_en;
    logic [3:0] branch_target;
    logic [3:0] rom_addr, pc;
    logic [7:0] rom_data, ir, retired;
    logic [2:0] opcode;
    logic [4:0] operand;
    logic       exec_valid, busy, halted;

    logic [7:0] rom_mem [16];
    assign rom_data = rom_mem[rom_addr];

    // One branch to address 0, taken the first time pc=2 completes while armed
    logic br_armed = 1'b0;
    int   br_taken = 0;
    assign branch_en     = br_armed && (br_taken == 0) && (pc == 4'd2);
    assign branch_target = 4'd0;

    always #5 clk = ~clk;

    instr_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .run           (run),
        .step          (step),
        .restart       (restart),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .ir            (ir),
        .opcode        (opcode),
        .operand       (operand),
        .exec_valid    (exec_valid),
        .exec_ready    (exec_ready),
        .branch_en     (branch_en),
        .branch_target (branch_target),
        .pc            (pc),
        .busy          (busy),
        .halted        (halted),
        .retired       (retired)
    );

    typedef struct {
        logic [7:0] word;
        logic [3:0] exp_pc;
        logic [2:0] exp_opc;
        logic [4:0] exp_opr;
    } vec_t;

    typedef struct {
        logic [7:0] ir;
        logic [3:0] pc;
        logic [2:0] opc;
        logic [4:0] opr;
    } exp_t;

    vec_t prog [5];
    exp_t sb_q [$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   sb_on = 1'b0;
    bit   chk_gap = 1'b0;
    int   cyc = 0;
    int   last_done = -1;
    int   ev_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic bit cond(input int sel);
        case (sel)
            0:       return exec_valid;
            1:       return halted;
            2:       return !busy;
            3:       return pc == 4'd15;
            4:       return pc != 4'd15;
            default: return retired == 8'hFF;
        endcase
    endfunction

    task automatic wait_cond(input string name, input int sel, input int budget);
        int n = 0;
        while (!cond(sel) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (!cond(sel)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: condition not reached within %0d cycles", name, budget);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic restart_pulse();
        tick();
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    task automatic push_exp(input int idx);
        exp_t e;
        e.ir  = prog[idx].word;
        e.pc  = prog[idx].exp_pc;
        e.opc = prog[idx].exp_opc;
        e.opr = prog[idx].exp_opr;
        sb_q.push_back(e);
    endtask

    task automatic load_prog();
        for (int i = 0; i < 16; i++) rom_mem[i] = 8'hFF;
        for (int i = 0; i < 5; i++) rom_mem[prog[i].exp_pc] = prog[i].word;
    endtask

    initial begin
        prog[0] = '{8'h60, 4'd0, 3'd3, 5'h00};
        prog[1] = '{8'h80, 4'd1, 3'd4, 5'h00};
        prog[2] = '{8'hA0, 4'd2, 3'd5, 5'h00};
        prog[3] = '{8'hC1, 4'd3, 3'd6, 5'h01};
        prog[4] = '{8'hFF, 4'd4, 3'd7, 5'h1F};
        load_prog();

        // Scoreboard monitor: every completion must match the queue head
        fork
            forever begin
                exp_t e;
                @(negedge clk);
                cyc++;
                if (exec_valid) ev_cnt++;
                if (!chk_gap) last_done = -1;
                if (sb_on && exec_valid && exec_ready) begin
                    if (sb_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL sb_extra: completion at pc=%0h ir=%0h with empty queue", pc, ir);
                    end else begin
                        e = sb_q.pop_front();
                        check("sb_ir", ir, e.ir);
                        check("sb_pc", pc, e.pc);
                        check("sb_opcode", opcode, e.opc);
                        check("sb_operand", operand, e.opr);
                        if (chk_gap && last_done >= 0) check("sb_gap", cyc - last_done, 3);
                        last_done = cyc;
                    end
                end
            end
            forever begin
                @(posedge clk);
                if (branch_en && exec_valid && exec_ready) br_taken <= br_taken + 1;
            end
        join_none

        // Reset state
        #1 rst = 1'b1;
        #2;
        check("rst_pc", pc, 0);
        check("rst_ir", ir, 0);
        check("rst_retired", retired, 0);
        check("rst_exec_valid", exec_valid, 0);
        check("rst_halted", halted, 0);
        check("rst_busy", busy, 0);
        tick();
        rst = 1'b0;

        // 1. Straight-line program to HALT, exec_ready tied high
        exec_ready = 1'b1;
        sb_on = 1'b1;
        chk_gap = 1'b1;
        for (int i = 0; i < 4; i++) push_exp(i);
        run = 1'b1;
        wait_cond("t1_halt", 1, 40);
        check("t1_halted", halted, 1);
        check("t1_pc", pc, prog[4].exp_pc);
        check("t1_retired", retired, 4);
        check("t1_ir", ir, prog[4].word);
        check("t1_opcode", opcode, prog[4].exp_opc);
        check("t1_operand", operand, prog[4].exp_opr);
        check("t1_exec_valid", exec_valid, 0);
        check("t1_busy", busy, 0);
        check("t1_drain", sb_q.size(), 0);
        repeat (4) tick();
        check("t1_halt_hold", halted, 1);
        run = 1'b0;
        chk_gap = 1'b0;

        // 2. restart leaves HALT; branch at pc=2 back to 0
        restart_pulse();
        check("t2_restart_halted", halted, 0);
        check("t2_restart_pc", pc, 0);
        check("t2_restart_retired", retired, 0);
        check("t2_restart_ir", ir, 0);
        check("t2_restart_busy", busy, 0);
        for (int i = 0; i < 3; i++) push_exp(i);
        for (int i = 0; i < 4; i++) push_exp(i);
        br_armed = 1'b1;
        chk_gap = 1'b1;
        run = 1'b1;
        wait_cond("t2_halt", 1, 60);
        check("t2_retired", retired, 7);
        check("t2_pc", pc, 4);
        check("t2_drain", sb_q.size(), 0);
        check("t2_branch_count", br_taken, 1);
        run = 1'b0;
        br_armed = 1'b0;
        chk_gap = 1'b0;

        // 3. Stall 5 cycles at pc=1
        restart_pulse();
        exec_ready = 1'b0;
        push_exp(0);
        push_exp(1);
        run = 1'b1;
        wait_cond("t3_ev0", 0, 10);
        exec_ready = 1'b1;
        tick();
        exec_ready = 1'b0;
        wait_cond("t3_ev1", 0, 10);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_stall_valid", exec_valid, 1);
            check("t3_stall_ir", ir, 8'h80);
            check("t3_stall_pc", pc, 1);
        end
        exec_ready = 1'b1;
        run = 1'b0;
        tick();
        check("t3_release_pc", pc, 2);
        check("t3_release_retired", retired, 2);
        tick();
        check("t3_idle", busy, 0);
        check("t3_drain", sb_q.size(), 0);

        // 4. Single-step with run low
        restart_pulse();
        push_exp(0);
        push_exp(1);
        for (int k = 1; k <= 2; k++) begin
            int ev0;
            ev0 = ev_cnt;
            step = 1'b1;
            tick();
            step = 1'b0;
            wait_cond("t4_idle", 2, 10);
            repeat (3) tick();
            check("t4_windows", ev_cnt - ev0, 1);
            check("t4_pc", pc, k);
            check("t4_retired", retired, k);
            check("t4_busy", busy, 0);
        end
        check("t4_drain", sb_q.size(), 0);

        // 5. PC wrap and retired saturation, no HALT in ROM
        sb_on = 1'b0;
        for (int i = 0; i < 16; i++) rom_mem[i] = 8'h20;
        restart_pulse();
        run = 1'b1;
        wait_cond("t5_pc15", 3, 60);
        wait_cond("t5_wrap", 4, 6);
        check("t5_wrap_pc", pc, 0);
        wait_cond("t5_sat", 5, 900);
        check("t5_sat_pc", pc, 15);
        repeat (7) tick();
        check("t5_sat_hold", retired, 8'hFF);
        check("t5_no_halt", halted, 0);
        run = 1'b0;
        wait_cond("t5_idle", 2, 6);

        // 6a. restart coincident with completion
        load_prog();
        restart_pulse();
        exec_ready = 1'b0;
        run = 1'b1;
        wait_cond("t6_ev0", 0, 10);
        exec_ready = 1'b1;
        tick();
        exec_ready = 1'b0;
        wait_cond("t6_ev1", 0, 10);
        check("t6_pre_retired", retired, 1);
        exec_ready = 1'b1;
        restart = 1'b1;
        run = 1'b0;
        tick();
        restart = 1'b0;
        exec_ready = 1'b0;
        check("t6_rs_retired", retired, 0);
        check("t6_rs_pc", pc, 0);
        check("t6_rs_ir", ir, 0);
        check("t6_rs_busy", busy, 0);
        tick();
        check("t6_rs_valid", exec_valid, 0);

        // 6b. Asynchronous rst mid-DECODE
        exec_ready = 1'b1;
        run = 1'b1;
        wait_cond("t6_ev2", 0, 10);
        tick();
        tick();
        check("t6_pre_dec_ir", ir, 8'h80);
        check("t6_pre_dec_pc", pc, 1);
        #2 rst = 1'b1;
        #1;
        check("t6_arst_pc", pc, 0);
        check("t6_arst_ir", ir, 0);
        check("t6_arst_retired", retired, 0);
        check("t6_arst_busy", busy, 0);
        check("t6_arst_valid", exec_valid, 0);
        check("t6_arst_halted", halted, 0);
        run = 1'b0;
        exec_ready = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
